pulse_pacer: RTL and testbench



---
 rtl/pulse_pacer_pkg.sv | 16 +
 rtl/pulse_pacer_sat_updown_cnt.sv | 26 ++
 rtl/pulse_pacer.sv | 87 ++++++++
 tb/tb_pulse_pacer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pacer_pkg.sv
// rtl/pulse_pacer_pkg.sv - shared state encoding and parameter legality check for pulse_pacer
package pulse_pacer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int GAP_MIN = 2;
  localparam int GAP_MAX = 65536;

  // Used at elaboration to reject GAP values the gap counter cannot represent.
  function automatic bit gap_is_legal(input int gap);
    return (gap >= GAP_MIN) && (gap <= GAP_MAX);
  endfunction

endpackage

// File: rtl/pulse_pacer_sat_updown_cnt.sv
// rtl/pulse_pacer_sat_updown_cnt.sv - saturating up/down counter; holds at all-ones and at zero
module sat_updown_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = &count;

  // Simultaneous inc and dec cancel, so a full counter can still accept while draining.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      count <= '0;
    end else if (inc && !dec && !sat) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_pacer.sv
// rtl/pulse_pacer.sv - backlogs event pulses and re-issues them at least GAP cycles apart
module pulse_pacer
  import pulse_pacer_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int GAP       = 16
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 i,
  input  logic                 clr_ovf,
  output logic                 o,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow
);

  localparam int              GW         = $clog2(GAP);
  localparam logic [GW-1:0]   GAP_RELOAD = GW'(GAP - 2);

  if (!gap_is_legal(GAP)) begin : g_gap_check
    $error("pulse_pacer: GAP must lie within 2..65536");
  end

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          start;
  logic          dec;
  logic          inc;
  logic          sat;
  logic          drop;

  assign start = i || (pending != '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_FIRE;
      ST_FIRE: state_nxt = ST_WAIT;
      ST_WAIT: if (gap_cnt == '0) state_nxt = start ? ST_FIRE : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // An issue slot consumes one event; an arriving event is only lost when no slot opens.
  assign dec  = (state_nxt == ST_FIRE);
  assign drop = i && sat && !dec;
  assign inc  = i && !drop;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      o       <= 1'b0;
    end else begin
      state <= state_nxt;
      o     <= dec;
      if (state == ST_FIRE) begin
        gap_cnt <= GAP_RELOAD;
      end else if ((state == ST_WAIT) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  sat_updown_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_backlog (
    .clk     (clk),
    .reset_l (reset_l),
    .inc     (inc),
    .dec     (dec),
    .count   (pending),
    .sat     (sat)
  );

endmodule

// File: tb/tb_pulse_pacer.sv
// tb/tb_pulse_pacer.sv - bench for pulse_pacer with a timestamp-based reference model
module tb_pulse_pacer;

  logic       clk   = 1'b0;
  logic       dclk  = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] i_v   = 3'b000;
  logic [2:0] clr_v = 3'b000;
  logic       o0, o1, o2;
  logic       ovf0, ovf1, ovf2;
  logic [7:0] pend0;
  logic [1:0] pend1;
  logic [7:0] pend2;

  pulse_pacer #(.CNT_WIDTH(8), .GAP(4)) u_pacer_g4 (
    .clk(clk), .reset_l(rst_v[0]), .i(i_v[0]), .clr_ovf(clr_v[0]),
    .o(o0), .pending(pend0), .overflow(ovf0)
  );

  pulse_pacer #(.CNT_WIDTH(2), .GAP(8)) u_pacer_sat (
    .clk(clk), .reset_l(rst_v[1]), .i(i_v[1]), .clr_ovf(clr_v[1]),
    .o(o1), .pending(pend1), .overflow(ovf1)
  );

  pulse_pacer #(.CNT_WIDTH(8), .GAP(16)) u_pacer_g16 (
    .clk(clk), .reset_l(rst_v[2]), .i(i_v[2]), .clr_ovf(clr_v[2]),
    .o(o2), .pending(pend2), .overflow(ovf2)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #7 dclk = ~dclk;
  end

  // Downstream req/ack toggle synchronizer; a pulse arriving while busy is lost.
  logic req = 1'b0, ack = 1'b0, ack_s1 = 1'b0, ack_s2 = 1'b0;
  logic req_d1 = 1'b0, req_d2 = 1'b0, req_d3 = 1'b0;
  int   src_pulses = 0, drops = 0, dst_pulses = 0;

  always @(negedge clk) begin
    ack_s1 <= ack;
    ack_s2 <= ack_s1;
    if (o2) begin
      src_pulses <= src_pulses + 1;
      if (req != ack_s2) drops <= drops + 1;
      else req <= ~req;
    end
  end

  always @(posedge dclk) begin
    req_d1 <= req;
    req_d2 <= req_d1;
    req_d3 <= req_d2;
    ack    <= req_d2;
    if (req_d2 != req_d3) dst_pulses <= dst_pulses + 1;
  end

  int gap_p [3] = '{4, 8, 16};
  int max_p [3] = '{255, 3, 255};
  int last_fire [3];
  int backlog [3];
  bit ovf_m [3];
  bit o_m [3];
  int cyc;
  int n_check = 0;
  int n_pass  = 0;

  function automatic int dut_o(input int d);
    case (d)
      0:       return int'(o0);
      1:       return int'(o1);
      default: return int'(o2);
    endcase
  endfunction

  function automatic int dut_pend(input int d);
    case (d)
      0:       return int'(pend0);
      1:       return int'(pend1);
      default: return int'(pend2);
    endcase
  endfunction

  function automatic int dut_ovf(input int d);
    case (d)
      0:       return int'(ovf0);
      1:       return int'(ovf1);
      default: return int'(ovf2);
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset(input int d);
    last_fire[d] = -1000;
    backlog[d]   = 0;
    ovf_m[d]     = 1'b0;
    o_m[d]       = 1'b0;
  endtask

  // A pulse may issue in cycle t when there was demand in t-1 and t is at least GAP after the last one.
  task automatic step();
    for (int d = 0; d < 3; d++) begin
      if (!rst_v[d]) begin
        model_reset(d);
      end else begin
        bit demand, fire, acc;
        demand = i_v[d] || (backlog[d] != 0);
        fire   = demand && (cyc + 1 >= last_fire[d] + gap_p[d]);
        acc    = i_v[d] && ((backlog[d] < max_p[d]) || fire);
        if (i_v[d] && !acc) ovf_m[d] = 1'b1;
        else if (clr_v[d])  ovf_m[d] = 1'b0;
        backlog[d] = backlog[d] + int'(acc) - int'(fire);
        if (fire) last_fire[d] = cyc + 1;
        o_m[d] = fire;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d c%0d o", d, cyc), dut_o(d), int'(o_m[d]));
      chk($sformatf("d%0d c%0d pending", d, cyc), dut_pend(d), backlog[d]);
      chk($sformatf("d%0d c%0d overflow", d, cyc), dut_ovf(d), int'(ovf_m[d]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int len;
    int sent;
    int q[$];

    cyc = 0;
    for (int d = 0; d < 3; d++) model_reset(d);
    #1 rst_v = 3'b000;
    repeat (2) step();
    rst_v = 3'b111;
    repeat (3) step();

    // single event, idle, GAP=4
    i_v[0] = 1'b1;
    step();
    i_v[0] = 1'b0;
    chk("single o@1", int'(o0), 1);
    chk("single pend@1", int'(pend0), 0);
    cnt = 0;
    for (int k = 2; k <= 9; k++) begin
      step();
      if (o0) cnt++;
    end
    chk("single extra pulses", cnt, 0);

    // burst of three, GAP=4
    cnt = 0;
    i_v[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) i_v[0] = 1'b0;
      if (o0) cnt++;
      if (k == 1) chk("burst o@1", int'(o0), 1);
      if (k == 2) chk("burst pend@2", int'(pend0), 1);
      if (k == 3) chk("burst pend@3", int'(pend0), 2);
      if (k == 5) chk("burst o@5", int'(o0), 1);
      if (k == 5) chk("burst pend@5", int'(pend0), 1);
      if (k == 9) chk("burst o@9", int'(o0), 1);
      if (k == 9) chk("burst pend@9", int'(pend0), 0);
    end
    chk("burst pulse count", cnt, 3);

    // saturation, CNT_WIDTH=2, GAP=8
    i_v[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 6) i_v[1] = 1'b0;
      if (o1) q.push_back(k);
      if (k == 4) chk("sat pend@4", int'(pend1), 3);
      if (k == 6) chk("sat ovf@6", int'(ovf1), 1);
    end
    chk("sat pulse count", q.size(), 4);
    for (int n = 0; n < 4 && n < q.size(); n++)
      chk($sformatf("sat pulse %0d cycle", n), q[n], 1 + 8 * n);

    clr_v[1] = 1'b1;
    step();
    clr_v[1] = 1'b0;
    chk("sat clr", int'(ovf1), 0);
    repeat (10) step();

    // increment at saturation coincident with an issue slot, then clear against a drop
    i_v[1] = 1'b1;
    repeat (4) step();
    i_v[1] = 1'b0;
    repeat (4) step();
    chk("coinc pend@8", int'(pend1), 3);
    i_v[1] = 1'b1;
    step();
    chk("coinc o@9", int'(o1), 1);
    chk("coinc pend@9", int'(pend1), 3);
    chk("coinc ovf@9", int'(ovf1), 0);
    step();
    chk("drop ovf@10", int'(ovf1), 1);
    clr_v[1] = 1'b1;
    step();
    chk("clr vs drop ovf@11", int'(ovf1), 1);
    i_v[1] = 1'b0;
    step();
    clr_v[1] = 1'b0;
    chk("clr alone ovf@12", int'(ovf1), 0);
    repeat (40) step();

    // reset with a backlog of 5, GAP=4
    i_v[0] = 1'b1;
    for (int k = 0; k < 20 && backlog[0] != 5; k++) step();
    i_v[0] = 1'b0;
    chk("rst backlog reached", int'(pend0), 5);
    rst_v[0] = 1'b0;
    #1;
    chk("rst o immediate", int'(o0), 0);
    chk("rst pend immediate", int'(pend0), 0);
    step();
    rst_v[0] = 1'b1;
    cnt = 0;
    repeat (20) begin
      step();
      if (o0) cnt++;
    end
    chk("rst no pulses", cnt, 0);

    // random bursts through the downstream synchronizer, GAP=16
    sent = 0;
    while (sent < 100) begin
      len = $urandom_range(1, 8);
      if (len > 100 - sent) len = 100 - sent;
      i_v[2] = 1'b1;
      repeat (len) step();
      sent += len;
      i_v[2] = 1'b0;
      len = $urandom_range(0, 30);
      repeat (len) step();
    end
    for (int k = 0; k < 3000 && backlog[2] != 0; k++) step();
    chk("sync drain pending", int'(pend2), 0);
    repeat (40) step();
    chk("sync src pulses", src_pulses, 100);
    chk("sync drops", drops, 0);
    chk("sync dst pulses", dst_pulses, 100);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
